// File: rtl/ws2812b_pkg.sv
// Shared FSM state type and default WS2812B timing (clk cycles at 64 MHz).
package ws2812b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_RES
    } ws_state_e;

    localparam int DEF_T0H_CYC  = 26;
    localparam int DEF_T1H_CYC  = 51;
    localparam int DEF_TBIT_CYC = 80;
    localparam int DEF_TRES_CYC = 19200;
    localparam int PIXEL_BITS   = 24;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812b_serializer_bit_timer.sv
// Down-counter shared by the HIGH, LOW and RES phases; done_o is high while the count is zero.
module ws2812b_bit_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ws2812b_serializer.sv
// WS2812B single-wire pixel serializer with a one-word holding buffer.
// Optional WS2812B_PWRON_RES_EN: emit one reset/latch period after reset release.
module ws2812b_serializer
    import ws2812b_pkg::*;
#(
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int TRES_CYC = DEF_TRES_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    input  logic        valid,
    input  logic        latch,
    output logic        ready,
    output logic        led
);

    localparam int CNT_W = $clog2(max_int(TBIT_CYC, TRES_CYC) + 1);

    // Timer reload values are one less than the phase length: the phase ends on the edge where the count is zero.
    localparam logic [CNT_W-1:0] LD_H0  = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0] LD_H1  = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0] LD_L0  = CNT_W'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [CNT_W-1:0] LD_L1  = CNT_W'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RES = CNT_W'(TRES_CYC - 1);

    ws_state_e        state_q, state_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic             pix_latch_q, pix_latch_d;
    logic [23:0]      buf_data_q, buf_data_d;
    logic             buf_latch_q, buf_latch_d;
    logic             buf_full_q, buf_full_d;
    logic             ready_q;
    logic             led_q;
`ifdef WS2812B_PWRON_RES_EN
    logic             pwron_q, pwron_d;
`endif

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             load_pixel;

    ws2812b_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        pix_latch_d = pix_latch_q;
        buf_data_d  = buf_data_q;
        buf_latch_d = buf_latch_q;
        buf_full_d  = buf_full_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        load_pixel  = 1'b0;
`ifdef WS2812B_PWRON_RES_EN
        pwron_d     = pwron_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef WS2812B_PWRON_RES_EN
                if (pwron_q) begin
                    pwron_d  = 1'b0;
                    state_d  = ST_RES;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RES;
                end else if (buf_full_q) begin
                    load_pixel = 1'b1;
                end
`else
                if (buf_full_q) begin
                    load_pixel = 1'b1;
                end
`endif
            end
            ST_HIGH: begin
                if (tmr_done) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = shift_q[23] ? LD_L1 : LD_L0;
                end
            end
            ST_LOW: begin
                if (tmr_done) begin
                    if (bit_idx_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                        state_d   = ST_HIGH;
                        tmr_load  = 1'b1;
                        tmr_val   = shift_q[22] ? LD_H1 : LD_H0;
                    end else if (pix_latch_q) begin
                        state_d  = ST_RES;
                        tmr_load = 1'b1;
                        tmr_val  = LD_RES;
                    end else if (buf_full_q) begin
                        load_pixel = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RES: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_pixel) begin
            shift_d     = buf_data_q;
            bit_idx_d   = 5'(PIXEL_BITS - 1);
            pix_latch_d = buf_latch_q;
            buf_full_d  = 1'b0;
            state_d     = ST_HIGH;
            tmr_load    = 1'b1;
            tmr_val     = buf_data_q[23] ? LD_H1 : LD_H0;
        end

        // Accept only reaches an empty buffer, so it never collides with load_pixel.
        if (valid && ready_q) begin
            buf_data_d  = data_in;
            buf_latch_d = latch;
            buf_full_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            pix_latch_q <= 1'b0;
            buf_data_q  <= '0;
            buf_latch_q <= 1'b0;
            buf_full_q  <= 1'b0;
            ready_q     <= 1'b1;
            led_q       <= 1'b0;
`ifdef WS2812B_PWRON_RES_EN
            pwron_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            pix_latch_q <= pix_latch_d;
            buf_data_q  <= buf_data_d;
            buf_latch_q <= buf_latch_d;
            buf_full_q  <= buf_full_d;
            ready_q     <= !buf_full_d;
            led_q       <= (state_d == ST_HIGH);
`ifdef WS2812B_PWRON_RES_EN
            pwron_q     <= pwron_d;
`endif
        end
    end

    assign ready = ready_q;
    assign led   = led_q;

endmodule

// File: tb/tb_ws2812b_serializer.sv
// Self-checking bench: led pulses are measured and compared against a pixel-level timing model.
`timescale 1ns/1ps
module tb_ws2812b_serializer;

    localparam int T0H  = 26;
    localparam int T1H  = 51;
    localparam int TBIT = 80;
    localparam int TRES = 19200;
    localparam int NBIT = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        latch = 1'b0;
    logic [23:0] data_in = '0;
    logic        ready;
    logic        led;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t pulse_q[$];
    int     exp_rise[$];
    int     exp_width[$];
    int     model_free = 0;
    int     led_rise = 0;
    logic   led_prev = 1'b0;

    ws2812b_serializer #(
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRES_CYC (TRES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .valid   (valid),
        .latch   (latch),
        .ready   (ready),
        .led     (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Samples after posedge number cyc; records each completed high pulse.
    always @(negedge clk) begin
        if (led === 1'b1 && led_prev !== 1'b1) led_rise <= cyc;
        if (led === 1'b0 && led_prev === 1'b1) pulse_q.push_back('{rise: led_rise, width: cyc - led_rise});
        led_prev <= led;
    end

    // Pixel-level model: a pixel starts the cycle after its accept edge, but not before the
    // line is free (previous pixel's 24 bit periods, plus the latch period and one idle cycle).
    function automatic int add_pixel(input logic [23:0] w, input logic l, input int acc);
        int start = (acc + 1 > model_free) ? acc + 1 : model_free;
        for (int b = NBIT - 1; b >= 0; b--) begin
            exp_rise.push_back(start + (NBIT - 1 - b) * TBIT);
            exp_width.push_back(w[b] ? T1H : T0H);
        end
        model_free = start + NBIT * TBIT + (l ? TRES + 1 : 0);
        return start;
    endfunction

    task automatic clear_queues();
        pulse_q.delete();
        exp_rise.delete();
        exp_width.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
`ifdef WS2812B_PWRON_RES_EN
        model_free = cyc + TRES + 2;
`else
        model_free = 0;
`endif
        clear_queues();
    endtask

    // Offers one word and returns the posedge number on which it was accepted.
    task automatic send(input logic [23:0] w, input logic l, output int acc);
        acc = -1;
        @(negedge clk);
        data_in = w;
        latch   = l;
        valid   = 1'b1;
        for (int n = 0; n < 4000 && acc < 0; n++) begin
            if (ready === 1'b1) acc = cyc + 1;
            @(negedge clk);
        end
        valid   = 1'b0;
        latch   = 1'b0;
        data_in = 24'($urandom);
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept: word %06h never accepted, required acceptance within 4000 cycles", w);
        end else begin
            $display("send word=%06h latch=%0b accepted at cycle %0d", w, l, acc);
        end
    endtask

    task automatic wait_pulses(output bit ok);
        int budget = exp_rise[exp_rise.size() - 1] + exp_width[exp_width.size() - 1] - cyc + 200;
        for (int t = 0; t < budget && pulse_q.size() < exp_rise.size(); t++) @(negedge clk);
        ok = (pulse_q.size() >= exp_rise.size());
    endtask

    task automatic test_reset();
        checks++;
        if (ready !== 1'b1 || led !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b led=%b, required ready=1 led=0", ready, led);
        end
        release_reset();
    endtask

    task automatic test_single();
        int acc;
        bit ok;
        clear_queues();
        send(24'h800001, 1'b0, acc);
        void'(add_pixel(24'h800001, 1'b0, acc));
        wait_pulses(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single timeout: pulses=%0d, required %0d", pulse_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size(); i++) begin
            int pr = (i < pulse_q.size()) ? pulse_q[i].rise : -1;
            int pw = (i < pulse_q.size()) ? pulse_q[i].width : -1;
            checks++;
            if (pr !== exp_rise[i] || pw !== exp_width[i]) begin
                errors++;
                $display("FAIL single bit%0d: rise=%0d width=%0d, required rise=%0d width=%0d", i, pr, pw, exp_rise[i], exp_width[i]);
            end
        end
        repeat (200) @(negedge clk);
        checks++;
        if (pulse_q.size() != exp_rise.size() || led !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL single idle: pulses=%0d led=%b ready=%b, required pulses=%0d led=0 ready=1", pulse_q.size(), led, ready, exp_rise.size());
        end
    endtask

    task automatic test_latch();
        int acc;
        bit ok;
        logic [23:0] w2;
        clear_queues();
        w2 = 24'($urandom);
        send(24'hFF0000, 1'b1, acc);
        void'(add_pixel(24'hFF0000, 1'b1, acc));
        send(w2, 1'b0, acc);
        void'(add_pixel(w2, 1'b0, acc));
        wait_pulses(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL latch timeout: pulses=%0d, required %0d", pulse_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size(); i++) begin
            int pr = (i < pulse_q.size()) ? pulse_q[i].rise : -1;
            int pw = (i < pulse_q.size()) ? pulse_q[i].width : -1;
            checks++;
            if (pr !== exp_rise[i] || pw !== exp_width[i]) begin
                errors++;
                $display("FAIL latch bit%0d: rise=%0d width=%0d, required rise=%0d width=%0d", i, pr, pw, exp_rise[i], exp_width[i]);
            end
        end
        repeat (200) @(negedge clk);
        checks++;
        if (pulse_q.size() != exp_rise.size() || led !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL latch idle: pulses=%0d led=%b ready=%b, required pulses=%0d led=0 ready=1", pulse_q.size(), led, ready, exp_rise.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, start_a;
        bit ok;
        logic [23:0] wa, wb;
        clear_queues();
        wa = 24'($urandom);
        wb = 24'($urandom);
        send(wa, 1'b0, acc_a);
        start_a = add_pixel(wa, 1'b0, acc_a);
        send(wb, 1'b0, acc_b);
        void'(add_pixel(wb, 1'b0, acc_b));
        checks++;
        if (acc_b !== start_a + 1) begin
            errors++;
            $display("FAIL b2b accept_edge: got %0d, required %0d", acc_b, start_a + 1);
        end
        wait_pulses(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b timeout: pulses=%0d, required %0d", pulse_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size(); i++) begin
            int pr = (i < pulse_q.size()) ? pulse_q[i].rise : -1;
            int pw = (i < pulse_q.size()) ? pulse_q[i].width : -1;
            checks++;
            if (pr !== exp_rise[i] || pw !== exp_width[i]) begin
                errors++;
                $display("FAIL b2b bit%0d: rise=%0d width=%0d, required rise=%0d width=%0d", i, pr, pw, exp_rise[i], exp_width[i]);
            end
        end
        repeat (200) @(negedge clk);
    endtask

    task automatic test_hold();
        int acc_a, acc_b, ready_seen;
        bit ok;
        logic [23:0] wa, wb;
        clear_queues();
        wa = 24'($urandom);
        wb = 24'($urandom);
        send(wa, 1'b0, acc_a);
        void'(add_pixel(wa, 1'b0, acc_a));
        send(wb, 1'b0, acc_b);
        void'(add_pixel(wb, 1'b0, acc_b));
        // A different word is held valid while the buffer is full; it must be ignored.
        data_in    = ~wb;
        latch      = 1'b1;
        valid      = 1'b1;
        ready_seen = 0;
        repeat (600) begin
            @(negedge clk);
            if (ready !== 1'b0) ready_seen++;
        end
        valid = 1'b0;
        latch = 1'b0;
        checks++;
        if (ready_seen != 0) begin
            errors++;
            $display("FAIL hold ready_low: ready high for %0d cycles, required 0", ready_seen);
        end
        wait_pulses(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold timeout: pulses=%0d, required %0d", pulse_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size(); i++) begin
            int pr = (i < pulse_q.size()) ? pulse_q[i].rise : -1;
            int pw = (i < pulse_q.size()) ? pulse_q[i].width : -1;
            checks++;
            if (pr !== exp_rise[i] || pw !== exp_width[i]) begin
                errors++;
                $display("FAIL hold bit%0d: rise=%0d width=%0d, required rise=%0d width=%0d", i, pr, pw, exp_rise[i], exp_width[i]);
            end
        end
        repeat (300) @(negedge clk);
        checks++;
        if (pulse_q.size() != exp_rise.size() || led !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL hold one_per_accept: pulses=%0d led=%b ready=%b, required pulses=%0d led=0 ready=1", pulse_q.size(), led, ready, exp_rise.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok;
        logic [23:0] wc;
        clear_queues();
        send(24'($urandom), 1'b0, acc);
        send(24'($urandom), 1'b0, acc);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (led !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid abort: led=%b ready=%b, required led=0 ready=1", led, ready);
        end
        repeat (2) @(negedge clk);
        release_reset();
        repeat (2500) @(negedge clk);
        checks++;
        if (pulse_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid discard: %0d pulses after reset, required 0", pulse_q.size());
        end
        wc = 24'($urandom);
        send(wc, 1'b0, acc);
        void'(add_pixel(wc, 1'b0, acc));
        wait_pulses(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid timeout: pulses=%0d, required %0d", pulse_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size(); i++) begin
            int pr = (i < pulse_q.size()) ? pulse_q[i].rise : -1;
            int pw = (i < pulse_q.size()) ? pulse_q[i].width : -1;
            checks++;
            if (pr !== exp_rise[i] || pw !== exp_width[i]) begin
                errors++;
                $display("FAIL reset_mid bit%0d: rise=%0d width=%0d, required rise=%0d width=%0d", i, pr, pw, exp_rise[i], exp_width[i]);
            end
        end
        repeat (200) @(negedge clk);
    endtask

    task automatic test_random();
        int acc;
        bit ok;
        logic [23:0] w;
        clear_queues();
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 1500)) @(negedge clk);
            w = 24'($urandom);
            send(w, 1'b0, acc);
            void'(add_pixel(w, 1'b0, acc));
        end
        wait_pulses(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random timeout: pulses=%0d, required %0d", pulse_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size(); i++) begin
            int pr = (i < pulse_q.size()) ? pulse_q[i].rise : -1;
            int pw = (i < pulse_q.size()) ? pulse_q[i].width : -1;
            checks++;
            if (pr !== exp_rise[i] || pw !== exp_width[i]) begin
                errors++;
                $display("FAIL random bit%0d: rise=%0d width=%0d, required rise=%0d width=%0d", i, pr, pw, exp_rise[i], exp_width[i]);
            end
        end
        repeat (200) @(negedge clk);
        checks++;
        if (pulse_q.size() != exp_rise.size() || led !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL random idle: pulses=%0d led=%b ready=%b, required pulses=%0d led=0 ready=1", pulse_q.size(), led, ready, exp_rise.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_latch();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
